present_dec: RTL and testbench
==============================

PRESENT_DEC -- requirements
Module: present_dec

Interface
REQ-001 SHALL have port sys_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port sys_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port decrypt_start, input, 1 bit: one-cycle request; sampled only in IDLE.
REQ-004 SHALL have port state, input, 64 bits [0:63]: ciphertext, in the bit order produced by the PRESENT encryptor's result output (bit-reversed).
REQ-005 SHALL have port keys, input, 80 bits [0:79]: user key; index 0 is MSB.
REQ-006 SHALL have port busy, output, 1 bit: high from the cycle after start acceptance until decrypt_end.
REQ-007 SHALL have port decrypt_end, output, 1 bit: one-cycle completion pulse.
REQ-008 SHALL have port result, output, 64 bits [0:63]: plaintext, in encryptor state-input order; held until the next accepted start.

Function
REQ-009 SHALL implement FSM states IDLE, KEYEXP, ROUND, DONE.
REQ-010 IDLE with decrypt_start=1 SHALL capture bitrev(state) into data register and keys into key register, then go to KEYEXP with cnt=1.
REQ-011 KEYEXP SHALL apply the forward key update once per cycle: rotate left 61, PRESENT S-box on k[0:3], XOR 5-bit cnt into k[60:64]; cnt runs 1..31; after cnt=31 go to ROUND with cnt=31.
REQ-012 ROUND entry cycle (cnt=31) SHALL first XOR k[0:63] (K32) into data.
REQ-013 Each ROUND cycle SHALL compute data = invS(invP(data)) then apply the inverse key update (XOR cnt into k[60:64], inverse S-box on k[0:3], rotate right 61), then XOR the new k[0:63] into data; cnt decrements 31..1.
REQ-014 After the cnt=1 round, the block SHALL load result with data and enter DONE.
REQ-015 DONE SHALL assert decrypt_end for exactly one cycle, deassert busy, and return to IDLE.
REQ-016 Total latency from start-accept edge to decrypt_end high SHALL be 63 cycles (31 KEYEXP + 31 ROUND + 1 DONE) without the cache.
REQ-017 decrypt_start while busy SHALL be ignored; state and keys are sampled only at acceptance.
REQ-018 decrypt_start in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-019 cnt SHALL be 5 bits and SHALL never wrap during an operation.

Reset
REQ-020 sys_rst_n=0 at any edge, including mid-operation, SHALL force IDLE, cnt=0, busy=0, decrypt_end=0, result=0, and clear the key cache valid bit.
REQ-021 Reset SHALL take priority over decrypt_start in the same cycle.

Configuration
REQ-022 Macro PRESENT_DEC_KEYCACHE_EN SHALL, when defined, store the last user key and its round-32 key register plus a valid bit; a start whose keys equal the cached key while valid SHALL load the cached key register and skip KEYEXP, giving a latency of 32 cycles.
REQ-023 Without PRESENT_DEC_KEYCACHE_EN, every operation SHALL run KEYEXP, with latency fixed at 63 cycles and no cache storage.

Structure
REQ-024 The S-box, inverse S-box, inverse pLayer functions and the round-count constant 31 SHALL reside in a shared package present_pkg, which the encryptor also uses.
REQ-025 One sub-module, present_inv_round, SHALL hold the combinational inverse round (invP, invS, inverse key update, key XOR), mirroring the encryptor's round sub-module.

Verification
REQ-026 state=bitrev(64'h5579C1387B228445), keys=0 -> result=0, decrypt_end at +63 cycles.
REQ-027 state=bitrev(64'hE72C46C0F5945049), keys=80'hFFFF_FFFF_FFFF_FFFF_FFFF -> result=0.
REQ-028 state=bitrev(64'h3333DCD3213210D2), keys=all ones -> result=64'hFFFF_FFFF_FFFF_FFFF; a second start pulsed at +10 cycles is ignored.
REQ-029 Start with keys=0; assert sys_rst_n=0 at +20 cycles -> busy=0, result=0 next cycle; then restart with bitrev(64'hA112FFC72F68417B), keys=0 -> result=all ones.
REQ-030 With PRESENT_DEC_KEYCACHE_EN, two back-to-back operations with the same key -> latency 63 then 32, both results correct; a changed key -> latency 63.
REQ-031 Loopback test: the encryptor output fed into this block for 100 random plaintext/key pairs -> result equals the original plaintext.

Source files
------------

// File: rtl/present_pkg.sv
// PRESENT-80 shared primitives: S-boxes, inverse pLayer, key schedule step.
// Shared by the encryptor and the present_dec decryptor.
package present_pkg;

    localparam logic [4:0] ROUNDS = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        KEYEXP,
        ROUND,
        DONE
    } dec_state_t;

    // nibble i of each table is the substitution of value i
    localparam logic [63:0] SBOX_TBL = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] INV_SBOX_TBL = 64'hA970_364B_D21C_8FE5;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TBL[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return INV_SBOX_TBL[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] inv_sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = inv_sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    function automatic logic [63:0] inv_player(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 63; i++) begin
            y[i] = x[(i * 16) % 63];
        end
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [79:0] key_fwd(
        input logic [79:0] k,
        input logic [4:0]  rc
    );
        logic [79:0] t;
        t = {k[18:0], k[79:19]};
        t[79:76] = sbox(t[79:76]);
        t[19:15] = t[19:15] ^ rc;
        return t;
    endfunction

    function automatic logic [63:0] bitrev64(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) begin
            y[i] = x[63 - i];
        end
        return y;
    endfunction

endpackage

// File: rtl/present_inv_round.sv
// PRESENT-80 combinational inverse round: invP, invS, key step back, key add.
module present_inv_round
    import present_pkg::*;
(
    input  logic [63:0] blk,
    input  logic [79:0] rkey,
    input  logic [4:0]  cnt,
    output logic [63:0] blk_nxt,
    output logic [79:0] rkey_nxt
);

    logic [79:0] k1;
    logic [63:0] d;

    always_comb begin
        d = inv_sbox_layer(inv_player(blk));
        k1 = rkey;
        k1[19:15] = k1[19:15] ^ cnt;
        k1[79:76] = inv_sbox(k1[79:76]);
        rkey_nxt = {k1[60:0], k1[79:61]};
        blk_nxt = d ^ rkey_nxt[79:16];
    end

endmodule

// File: rtl/present_dec.sv
// PRESENT-80 iterative decryptor, one round per cycle.
// Optional round-32 key cache: define PRESENT_DEC_KEYCACHE_EN.
module present_dec
    import present_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        decrypt_start,
    input  logic [0:63] state,
    input  logic [0:79] keys,
    output logic        busy,
    output logic        decrypt_end,
    output logic [0:63] result
);

    dec_state_t  st, st_n;
    logic [4:0]  cnt, cnt_n;
    logic [63:0] data, data_n;
    logic [79:0] key, key_n;
    logic [0:63] res_n;
    logic        busy_n, end_n;
    logic [63:0] round_blk, blk_nxt;
    logic [79:0] rkey_nxt;
    logic        hit;
    logic [79:0] hit_rk;

`ifdef PRESENT_DEC_KEYCACHE_EN
    logic        cache_vld;
    logic [79:0] cache_key;
    logic [79:0] cache_rk;

    assign hit = cache_vld && (cache_key == keys);
    assign hit_rk = cache_rk;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cache_vld <= 1'b0;
            cache_key <= '0;
            cache_rk  <= '0;
        end else if (st == IDLE && decrypt_start && !hit) begin
            cache_vld <= 1'b0;
            cache_key <= keys;
        end else if (st == KEYEXP && cnt == ROUNDS) begin
            cache_vld <= 1'b1;
            cache_rk  <= key_n;
        end
    end
`else
    assign hit = 1'b0;
    assign hit_rk = '0;
`endif

    // first round cycle also strips the final whitening key K32
    assign round_blk = (cnt == ROUNDS) ? (data ^ key[79:16]) : data;

    present_inv_round u_round (
        .blk      (round_blk),
        .rkey     (key),
        .cnt      (cnt),
        .blk_nxt  (blk_nxt),
        .rkey_nxt (rkey_nxt)
    );

    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        data_n = data;
        key_n  = key;
        res_n  = result;
        busy_n = busy;
        end_n  = 1'b0;
        unique case (st)
            IDLE: begin
                if (decrypt_start) begin
                    data_n = bitrev64(state);
                    key_n  = keys;
                    busy_n = 1'b1;
                    if (hit) begin
                        key_n = hit_rk;
                        cnt_n = ROUNDS;
                        st_n  = ROUND;
                    end else begin
                        cnt_n = 5'd1;
                        st_n  = KEYEXP;
                    end
                end
            end
            KEYEXP: begin
                key_n = key_fwd(key, cnt);
                if (cnt == ROUNDS) begin
                    st_n = ROUND;
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end
            ROUND: begin
                data_n = blk_nxt;
                key_n  = rkey_nxt;
                cnt_n  = cnt - 5'd1;
                if (cnt == 5'd1) begin
                    res_n = blk_nxt;
                    st_n  = DONE;
                end
            end
            DONE: begin
                busy_n = 1'b0;
                end_n  = 1'b1;
                st_n   = IDLE;
            end
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            st          <= IDLE;
            cnt         <= '0;
            data        <= '0;
            key         <= '0;
            result      <= '0;
            busy        <= 1'b0;
            decrypt_end <= 1'b0;
        end else begin
            st          <= st_n;
            cnt         <= cnt_n;
            data        <= data_n;
            key         <= key_n;
            result      <= res_n;
            busy        <= busy_n;
            decrypt_end <= end_n;
        end
    end

endmodule

// File: tb/tb_present_dec.sv
// Self-checking bench for present_dec against a forward PRESENT-80 model.
module tb_present_dec;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        decrypt_start;
    logic [0:63] state;
    logic [0:79] keys;
    logic        busy;
    logic        decrypt_end;
    logic [0:63] result;

    int checks = 0;
    int errors = 0;

    logic [3:0]  sb [16];
    bit          mdl_vld;
    logic [79:0] mdl_key;

    always #5 sys_clk = ~sys_clk;

    present_dec dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .decrypt_start (decrypt_start),
        .state         (state),
        .keys          (keys),
        .busy          (busy),
        .decrypt_end   (decrypt_end),
        .result        (result)
    );

    function automatic logic [63:0] bitrev(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[i] = x[63 - i];
        return y;
    endfunction

    function automatic logic [63:0] encrypt(
        input logic [63:0] p,
        input logic [79:0] kin
    );
        logic [63:0] s, t;
        logic [79:0] k;
        s = p;
        k = kin;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sb[s[4*n +: 4]];
            t = '0;
            for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
            s = t;
            k = {k[18:0], k[79:19]};
            k[79:76] = sb[k[79:76]];
            k[19:15] = k[19:15] ^ r[4:0];
        end
        return s ^ k[79:16];
    endfunction

    function automatic int exp_lat(input logic [79:0] k);
`ifdef PRESENT_DEC_KEYCACHE_EN
        return (mdl_vld && mdl_key == k) ? 32 : 63;
`else
        return 63;
`endif
    endfunction

    function automatic logic [79:0] rand_key();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // One operation; lat = cycles from accept edge to decrypt_end, -1 on timeout
    task automatic run_op(
        input  logic [63:0] c,
        input  logic [79:0] k,
        input  int          ign_at,
        output int          lat,
        output int          e
    );
        e = exp_lat(k);
        @(negedge sys_clk);
        state = bitrev(c);
        keys = k;
        decrypt_start = 1'b1;
        @(negedge sys_clk);
        decrypt_start = 1'b0;
        state = {$urandom, $urandom};
        keys = rand_key();
        lat = 0;
        while (decrypt_end !== 1'b1 && lat < 100) begin
            decrypt_start = (ign_at != 0 && lat == ign_at);
            @(negedge sys_clk);
            lat++;
        end
        decrypt_start = 1'b0;
        if (decrypt_end !== 1'b1) lat = -1;
        mdl_vld = 1'b1;
        mdl_key = k;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        decrypt_start = 1'b1;
        repeat (2) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (decrypt_end !== 1'b0) begin
            errors++;
            $display("FAIL reset_end got %b want 0", decrypt_end);
        end
        checks++;
        if (result !== 64'h0) begin
            errors++;
            $display("FAIL reset_result got %h want 0", result);
        end
        decrypt_start = 1'b0;
        sys_rst_n = 1'b1;
        mdl_vld = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy got %b want 0", busy);
        end
    endtask

    task automatic test_vectors();
        logic [63:0] c [3];
        logic [79:0] k [3];
        logic [63:0] p [3];
        int lat, e;
        c[0] = 64'h5579C1387B228445; k[0] = '0; p[0] = '0;
        c[1] = 64'hE72C46C0F5945049; k[1] = '1; p[1] = '0;
        c[2] = 64'h3333DCD3213210D2; k[2] = '1; p[2] = '1;
        for (int i = 0; i < 3; i++) begin
            run_op(c[i], k[i], (i == 2) ? 10 : 0, lat, e);
            checks++;
            if (result !== p[i]) begin
                errors++;
                $display("FAIL vec%0d_result got %h want %h", i, result, p[i]);
            end
            checks++;
            if (lat != e) begin
                errors++;
                $display("FAIL vec%0d_latency got %0d want %0d", i, lat, e);
            end
        end
        @(negedge sys_clk);
        checks++;
        if (decrypt_end !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL end_pulse got end=%b busy=%b want 0 0",
                     decrypt_end, busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat, e;
        @(negedge sys_clk);
        state = {$urandom, $urandom};
        keys = '0;
        decrypt_start = 1'b1;
        @(negedge sys_clk);
        decrypt_start = 1'b0;
        repeat (19) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0 || decrypt_end !== 1'b0) begin
            errors++;
            $display("FAIL midrst_flags got busy=%b end=%b want 0 0",
                     busy, decrypt_end);
        end
        checks++;
        if (result !== 64'h0) begin
            errors++;
            $display("FAIL midrst_result got %h want 0", result);
        end
        sys_rst_n = 1'b1;
        mdl_vld = 1'b0;
        run_op(64'hA112FFC72F68417B, '0, 0, lat, e);
        checks++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL midrst_rerun got %h want ffffffffffffffff", result);
        end
        checks++;
        if (lat != e) begin
            errors++;
            $display("FAIL midrst_latency got %0d want %0d", lat, e);
        end
    endtask

    task automatic test_done_start();
        logic [79:0] k;
        logic [63:0] p1, p2;
        int lat, e;
        k = mdl_key ^ 80'h1;
        p1 = {$urandom, $urandom};
        p2 = {$urandom, $urandom};
        @(negedge sys_clk);
        state = bitrev(encrypt(p1, k));
        keys = k;
        decrypt_start = 1'b1;
        @(negedge sys_clk);
        decrypt_start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept got %b want 1", busy);
        end
        repeat (62) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b1 || decrypt_end !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle got busy=%b end=%b want 1 0",
                     busy, decrypt_end);
        end
        state = bitrev(encrypt(p2, k));
        decrypt_start = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (decrypt_end !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL first_end got end=%b busy=%b want 1 0",
                     decrypt_end, busy);
        end
        checks++;
        if (result !== p1) begin
            errors++;
            $display("FAIL first_result got %h want %h", result, p1);
        end
        mdl_vld = 1'b1;
        mdl_key = k;
        e = exp_lat(k);
        @(negedge sys_clk);
        decrypt_start = 1'b0;
        lat = 0;
        while (decrypt_end !== 1'b1 && lat < 100) begin
            @(negedge sys_clk);
            lat++;
        end
        if (decrypt_end !== 1'b1) lat = -1;
        checks++;
        if (lat != e) begin
            errors++;
            $display("FAIL idle_start_latency got %0d want %0d", lat, e);
        end
        checks++;
        if (result !== p2) begin
            errors++;
            $display("FAIL idle_start_result got %h want %h", result, p2);
        end
    endtask

    task automatic test_back_to_back();
        logic [79:0] k, kk;
        logic [63:0] p;
        int lat, e;
        k = rand_key();
        for (int i = 0; i < 3; i++) begin
            kk = (i == 2) ? (k ^ 80'h8000) : k;
            p = {$urandom, $urandom};
            run_op(encrypt(p, kk), kk, 0, lat, e);
            checks++;
            if (result !== p) begin
                errors++;
                $display("FAIL b2b%0d_result got %h want %h", i, result, p);
            end
            checks++;
            if (lat != e) begin
                errors++;
                $display("FAIL b2b%0d_latency got %0d want %0d", i, lat, e);
            end
        end
    endtask

    task automatic test_loopback();
        logic [79:0] k;
        logic [63:0] p;
        int lat, e, ign;
        k = rand_key();
        for (int i = 0; i < 100; i++) begin
            if (i % 4 != 3) k = rand_key();
            p = {$urandom, $urandom};
            ign = ($urandom_range(1) == 1) ? int'($urandom_range(1, 40)) : 0;
            run_op(encrypt(p, k), k, ign, lat, e);
            checks++;
            if (result !== p) begin
                errors++;
                $display("FAIL loop%0d_result got %h want %h", i, result, p);
            end
            checks++;
            if (lat != e) begin
                errors++;
                $display("FAIL loop%0d_latency got %0d want %0d", i, lat, e);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        mdl_vld = 1'b0;
        mdl_key = '0;
        sys_rst_n = 1'b0;
        decrypt_start = 1'b0;
        state = '0;
        keys = '0;
        test_reset();
        test_vectors();
        test_reset_mid();
        test_done_start();
        test_back_to_back();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
